// File: rtl/dm_pkg.sv
// Shared encodings for the parametrised MEM-stage data memory.
package dm_pkg;

  // Access size codes driven by the pipeline; 2'b11 is reserved and always faults.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Memory controller states.
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // Expand a 4-bit byte-lane mask into a 32-bit bit mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for stores and lane selection/extension for loads.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic        unsigned_i,
  output logic [3:0]  lane_mask_o,
  output logic [31:0] wdata_lane_o,
  output logic        misaligned_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Store side: replicate the datum into every lane so the mask alone picks the target.
  always_comb begin
    lane_mask_o  = 4'b0000;
    wdata_lane_o = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        lane_mask_o  = 4'b0001 << addr_lo_i;
        wdata_lane_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        lane_mask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_lane_o = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      SIZE_WORD: begin
        lane_mask_o  = 4'b1111;
        wdata_lane_o = wdata_i;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
    // A faulting store must not touch any lane.
    if (misaligned_o) lane_mask_o = 4'b0000;
  end

  // Load side: pick the addressed lane(s) and sign/zero-extend.
  always_comb begin
    rdata_o = 32'h0;
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SIZE_WORD: rdata_o = rword_i;
      default:   rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_param.sv
// MEM-stage data memory: byte-lane stores, extended loads, alignment fault capture and a
// post-reset clear sweep that holds Ready low until every word is zero.
module dm_param
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter bit          TRACE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [31:0] PC_Now,
  input  logic        ReadEn,
  input  logic        WriteEn,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AlignErr,
  output logic        ErrValid,
  output logic [31:0] ErrAddr
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [Words];
  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic                  err_valid_q, err_valid_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic [3:0]            lane_mask;
  logic [31:0]           wdata_lane;
  logic                  misaligned;
  logic [31:0]           rdata_ext;
  logic                  running;
  logic                  store_commit;
  logic [31:0]           merged_word;

  // Upper address bits wrap; the PC only feeds the optional trace.
  logic unused_sig;
  assign unused_sig = ^{Address[31:DEPTH_LOG2+2], PC_Now};

  assign idx     = Address[DEPTH_LOG2+1:2];
  assign rd_word = mem_q[idx];
  assign running = (state_q == RUN);

  dm_lane_align u_lane_align (
    .size_i       (Size),
    .addr_lo_i    (Address[1:0]),
    .wdata_i      (WriteData),
    .rword_i      (rd_word),
    .unsigned_i   (Unsigned),
    .lane_mask_o  (lane_mask),
    .wdata_lane_o (wdata_lane),
    .misaligned_o (misaligned),
    .rdata_o      (rdata_ext)
  );

  assign store_commit = running & WriteEn & ~misaligned;
  assign merged_word  = (rd_word & ~lane_bits(lane_mask)) | (wdata_lane & lane_bits(lane_mask));

  assign Ready    = running;
  assign AlignErr = running & (ReadEn | WriteEn) & misaligned;
  assign ReadData = (running & ReadEn & ~misaligned) ? rdata_ext : 32'h0;
  assign ErrValid = err_valid_q;
  assign ErrAddr  = err_addr_q;

  // Next state: advance the sweep, then capture only the first alignment fault.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (!running) begin
      clr_ptr_d = clr_ptr_q + DEPTH_LOG2'(1);
      if (&clr_ptr_q) state_d = RUN;
    end else if (AlignErr && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_addr_d  = Address;
    end
  end

  // Control and error registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Array: zero one word per cycle while clearing, otherwise byte-enabled store.
  always_ff @(posedge clk) begin
    if (!running) begin
      mem_q[clr_ptr_q] <= 32'h0;
    end else if (store_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem_q[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  if (TRACE_EN) begin : g_trace
    // Print one line for every committed store, showing the merged word.
    always_ff @(posedge clk) begin
      if (Reset && store_commit) $display("@%h: *%h <= %h", PC_Now, Address, merged_word);
    end
  end

endmodule

// File: tb/tb_dm_param.sv
// Scoreboard bench for dm_param against a byte-addressed reference memory.
module tb_dm_param;

  localparam int unsigned DepthLog2 = 10;
  localparam int unsigned MemBytes  = 4 << DepthLog2;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Address = '0, WriteData = '0, PC_Now = '0;
  logic        ReadEn = 1'b0, WriteEn = 1'b0, Unsigned = 1'b0;
  logic [1:0]  Size = 2'b10;
  logic [31:0] ReadData, ErrAddr;
  logic        Ready, AlignErr, ErrValid;

  dm_param #(.DEPTH_LOG2(DepthLog2), .TRACE_EN(1'b1)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Address   (Address),
    .WriteData (WriteData),
    .PC_Now    (PC_Now),
    .ReadEn    (ReadEn),
    .WriteEn   (WriteEn),
    .Size      (Size),
    .Unsigned  (Unsigned),
    .ReadData  (ReadData),
    .Ready     (Ready),
    .AlignErr  (AlignErr),
    .ErrValid  (ErrValid),
    .ErrAddr   (ErrAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        ae;
    logic        ev;
    logic [31:0] ea;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: flat byte memory plus sticky fault record.
  logic [7:0]  m_bytes [MemBytes];
  logic        m_ev;
  logic [31:0] m_ea;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    int n;
    if (sz == 2'b11) return 1'b1;
    n = 1 << sz;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr);
    int          n    = 1 << sz;
    int          base = int'(addr % MemBytes);
    logic [31:0] v    = 32'h0;
    logic [31:0] keep;
    for (int i = 0; i < n; i++) v = v | (32'(m_bytes[base + i]) << (8 * i));
    if (n < 4) begin
      keep = (32'h1 << (8 * n)) - 32'h1;
      if (!uns && v[8*n-1]) v = v | ~keep;
    end
    return v;
  endfunction

  // One pipeline access: drive at negedge, push expected, update model for the edge.
  task automatic op(input logic re, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wd, input string nm);
    exp_t e;
    bit   mis;
    int   base;
    ReadEn = re; WriteEn = we; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
    PC_Now = PC_Now + 32'd4;
    #1;
    mis    = m_misaligned(sz, addr);
    e.name = nm;
    e.rd   = (re && !mis) ? m_load(sz, uns, addr) : 32'h0;
    e.ae   = (re || we) && mis;
    e.ev   = m_ev;
    e.ea   = m_ea;
    exp_q.push_back(e);
    if ((re || we) && mis && !m_ev) begin
      m_ev = 1'b1;
      m_ea = addr;
    end
    if (we && !mis) begin
      base = int'(addr % MemBytes);
      for (int i = 0; i < (1 << sz); i++) m_bytes[base + i] = wd[8*i +: 8];
    end
    @(negedge clk);
  endtask

  // Monitor: compare just before each active edge, once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, " ReadData"}, ReadData, e.rd);
        check({e.name, " AlignErr"}, 32'(AlignErr), 32'(e.ae));
        check({e.name, " Ready"}, 32'(Ready), 32'h1);
        check({e.name, " ErrValid"}, 32'(ErrValid), 32'(e.ev));
        check({e.name, " ErrAddr"}, ErrAddr, e.ea);
      end
    end
  end

  task automatic m_reset();
    for (int i = 0; i < MemBytes; i++) m_bytes[i] = 8'h0;
    m_ev = 1'b0;
    m_ea = 32'h0;
  endtask

  // Hold reset, release it and time the sweep; misaligned reads during CLEAR must be ignored.
  task automatic do_reset(input int cycles, input string nm);
    int cnt = 0;
    @(negedge clk);
    Reset = 1'b0; ReadEn = 1'b0; WriteEn = 1'b0;
    #1;
    check({nm, " reset Ready"}, 32'(Ready), 32'h0);
    check({nm, " reset ErrValid"}, 32'(ErrValid), 32'h0);
    check({nm, " reset ErrAddr"}, ErrAddr, 32'h0);
    repeat (cycles) @(negedge clk);
    Reset = 1'b1;
    ReadEn = 1'b1; WriteEn = 1'b1; Size = 2'b10; Address = 32'h3; WriteData = 32'hDEAD_BEEF;
    while (!Ready && cnt < 4 * MemBytes) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 100) begin
        check({nm, " clear ReadData"}, ReadData, 32'h0);
        check({nm, " clear AlignErr"}, 32'(AlignErr), 32'h0);
      end
    end
    ReadEn = 1'b0; WriteEn = 1'b0;
    check({nm, " sweep cycles"}, 32'(cnt), 32'(1 << DepthLog2));
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    do_reset(3, "t1");
    op(1, 0, 2'b10, 0, 32'h3FC, 0, "t1 lw 3fc");
    op(1, 0, 2'b10, 0, 32'h10, 0, "t1 lw 10");

    op(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, "t2 sw");
    op(0, 1, 2'b00, 0, 32'h11, 32'h0000_00AA, "t2 sb");
    op(1, 0, 2'b10, 0, 32'h10, 0, "t2 lw");
    op(1, 0, 2'b00, 0, 32'h11, 0, "t2 lb");
    op(1, 0, 2'b00, 1, 32'h11, 0, "t2 lbu");

    op(0, 1, 2'b01, 0, 32'h22, 32'h0000_8001, "t3 sh");
    op(1, 0, 2'b01, 0, 32'h22, 0, "t3 lh");
    op(1, 0, 2'b01, 1, 32'h22, 0, "t3 lhu");
    op(1, 0, 2'b10, 0, 32'h20, 0, "t3 lw");

    op(0, 1, 2'b10, 0, 32'h13, 32'hFFFF_FFFF, "t4 sw mis");
    op(1, 0, 2'b01, 0, 32'h41, 0, "t4 lh mis");
    op(1, 0, 2'b10, 0, 32'h10, 0, "t4 lw 10");
    op(1, 1, 2'b11, 0, 32'h50, 32'h1, "t4 size11");

    op(1, 1, 2'b10, 0, 32'h30, 32'h5, "t6 rw same");
    op(1, 0, 2'b10, 0, 32'h30, 0, "t6 rw next");

    // Restart mid-sweep after writes in RUN; everything must read back zero.
    op(0, 1, 2'b10, 0, 32'h0, 32'hCAFE_F00D, "t5 sw 0");
    op(0, 1, 2'b10, 0, 32'h14, 32'h1234_5678, "t5 sw 14");
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("t5 first reset Ready", 32'(Ready), 32'h0);
    check("t5 first reset ErrValid", 32'(ErrValid), 32'h0);
    @(negedge clk);
    Reset = 1'b1;
    repeat (5) @(posedge clk);
    do_reset(1, "t5");
    for (int a = 0; a < 64; a += 4) op(1, 0, 2'b10, 0, 32'(a), 0, "t5 lw zero");
    op(1, 0, 2'b10, 0, 32'hFFC, 0, "t5 lw last");

    // Random traffic over a small window with occasional wrapping upper bits.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] addr;
      addr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF_F000);
      op(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), addr, $urandom,
         "rand");
    end

    ReadEn = 1'b0; WriteEn = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
